// File: rtl/ps2_key_event_rx_if.sv
// Key event stream from the PS/2 receiver to its consumer (seg display, CPU).
// Handshake: a transfer happens on a clk edge where ev_valid && ev_ready; while
// ev_valid is high and ev_ready low, ev_code/ev_brk/ev_ext do not change.
interface ps2_key_event_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_brk;
  logic       ev_ext;

  modport master (
    output ev_valid,
    output ev_code,
    output ev_brk,
    output ev_ext,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_code,
    input  ev_brk,
    input  ev_ext,
    output ev_ready
  );
endinterface

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: frame deserialiser, E0/F0 prefix folding, event FIFO, statistics.
// Define PS2_TYPEMATIC_FILTER_EN to drop auto-repeated make codes.
module ps2_key_event_rx #(
  parameter int SYNC_STAGES = 3,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  ps2_key_event_if.master               ev,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [CNT_W-1:0]              err_parity_cnt,
  output logic [CNT_W-1:0]              err_frame_cnt,
  output logic [CNT_W-1:0]              press_cnt,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Input synchronisers and edge detect
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic                   clk_cur, data_cur, sample;

  // Frame FSM
  state_t                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   byte_ok, err_par, err_frm;

  // Prefix decode
  logic                   ext_pend_q, ext_pend_d;
  logic                   brk_pend_q, brk_pend_d;
  logic                   push;
  logic [9:0]             push_word;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic                   trk_valid_q, trk_valid_d;
  logic [8:0]             trk_key_q, trk_key_d;
`endif

  // Event FIFO
  logic [9:0]             mem_q [FIFO_DEPTH];
  logic [9:0]             mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic [9:0]             head_q, head_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic                   pop, full, wr_en;

  // Statistics
  logic [CNT_W-1:0]       perr_q, perr_d;
  logic [CNT_W-1:0]       ferr_q, ferr_d;
  logic [CNT_W-1:0]       press_q, press_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_cur     = clk_sync_q[SYNC_STAGES-1];
    data_cur    = data_sync_q[SYNC_STAGES-1];
    clk_prev_d  = clk_cur;
    sample      = clk_prev_q & ~clk_cur;
  end

  // One FSM step per sample; the timer only runs while a frame is in progress.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    timer_d   = timer_q;
    byte_ok   = 1'b0;
    err_par   = 1'b0;
    err_frm   = 1'b0;
    if (state_q == S_IDLE) begin
      timer_d = '0;
      if (sample && !data_cur) begin
        state_d   = S_DATA;
        bit_cnt_d = 3'd0;
      end
    end else if (sample) begin
      timer_d = '0;
      if (state_q == S_DATA) begin
        shift_d   = {data_cur, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = S_PARITY;
      end else if (state_q == S_PARITY) begin
        par_d   = data_cur;
        state_d = S_STOP;
      end else begin
        state_d = S_IDLE;
        if (!data_cur)                err_frm = 1'b1;
        else if (!(^{shift_q, par_q})) err_par = 1'b1;
        else                          byte_ok = 1'b1;
      end
    end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = S_IDLE;
      timer_d = '0;
      err_frm = 1'b1;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_comb begin
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    push       = 1'b0;
    push_word  = {brk_pend_q, ext_pend_q, shift_q};
`ifdef PS2_TYPEMATIC_FILTER_EN
    trk_valid_d = trk_valid_q;
    trk_key_d   = trk_key_q;
`endif
    if (err_frm || err_par) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (byte_ok) begin
      if (shift_q == 8'hE0) begin
        ext_pend_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_pend_d = 1'b1;
      end else begin
        push       = 1'b1;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        // A repeated make of the held key is auto-repeat; its break re-arms the tracker.
        if (!brk_pend_q) begin
          if (trk_valid_q && trk_key_q == {ext_pend_q, shift_q}) begin
            push = 1'b0;
          end else begin
            trk_valid_d = 1'b1;
            trk_key_d   = {ext_pend_q, shift_q};
          end
        end else if (trk_valid_q && trk_key_q == {ext_pend_q, shift_q}) begin
          trk_valid_d = 1'b0;
        end
`endif
      end
    end
  end

  // Show-ahead FIFO with a registered head so fields hold their value when empty.
  always_comb begin
    pop      = valid_q && ev.ev_ready;
    full     = (count_q == (AW+1)'(FIFO_DEPTH));
    wr_en    = push && (!full || pop);
    mem_d    = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = push_word;
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    ovf_d    = ovf_q | (push && full && !pop);
    valid_d  = (count_d != '0);
    head_d   = head_q;
    if (count_d != '0) begin
      if (wr_en && (wr_ptr_q == rd_ptr_d)) head_d = push_word;
      else                                  head_d = mem_q[rd_ptr_d];
    end
  end

  always_comb begin
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    press_d = press_q;
    if (err_par && (perr_q != '1)) perr_d = perr_q + CNT_W'(1);
    if (err_frm && (ferr_q != '1)) ferr_d = ferr_q + CNT_W'(1);
    if (wr_en && !push_word[9])    press_d = press_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      timer_q     <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      trk_valid_q <= 1'b0;
      trk_key_q   <= '0;
`endif
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      perr_q      <= '0;
      ferr_q      <= '0;
      press_q     <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      timer_q     <= timer_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
      trk_valid_q <= trk_valid_d;
      trk_key_q   <= trk_key_d;
`endif
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      press_q     <= press_d;
    end
  end

  assign ev.ev_valid    = valid_q;
  assign ev.ev_brk      = head_q[9];
  assign ev.ev_ext      = head_q[8];
  assign ev.ev_code     = head_q[7:0];
  assign fifo_level     = count_q;
  assign overflow       = ovf_q;
  assign err_parity_cnt = perr_q;
  assign err_frame_cnt  = ferr_q;
  assign press_cnt      = press_q;
  assign dbg_state      = state_q;

endmodule
